// File: rtl/fractal_sync_nd_node.sv
// Purpose : N-child barrier aggregation node of the fractal sync tree; one entry per barrier id.
// Latency : root completion -> child response 1 cycle; upstream response -> child response 1 cycle.
// Backpr. : request ready per child from the entry state; upstream payload held until ready;
//           each child response port drains independently.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/req_ready_o            per-child arrival handshake (req_aggr_i, req_id_i payload)
//   rsp_valid_o/rsp_ready_i            per-child barrier release (rsp_id_o payload)
//   up_req_valid_o/up_req_ready_i      aggregated request to parent (up_req_aggr_o, up_req_id_o)
//   up_rsp_valid_i, up_rsp_id_i        parent release, always accepted
//   error_o                            one-cycle pulse for any protocol error in the previous cycle
//   busy_o                             some barrier id is not idle
// Optional: define FRACTAL_SYNC_ND_TIMEOUT_EN to abandon collections idle for TIMEOUT_CYCLES.

module fractal_sync_nd_node #(
    parameter int unsigned N_PORTS        = 4,
    parameter int unsigned LEVEL          = 0,
    parameter int unsigned AGGR_W         = 8,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_PORTS-1:0]             req_valid_i,
    output logic [N_PORTS-1:0]             req_ready_o,
    input  logic [N_PORTS-1:0][AGGR_W-1:0] req_aggr_i,
    input  logic [N_PORTS-1:0][ID_W-1:0]   req_id_i,
    output logic [N_PORTS-1:0]             rsp_valid_o,
    input  logic [N_PORTS-1:0]             rsp_ready_i,
    output logic [N_PORTS-1:0][ID_W-1:0]   rsp_id_o,
    output logic                           up_req_valid_o,
    input  logic                           up_req_ready_i,
    output logic [AGGR_W-1:0]              up_req_aggr_o,
    output logic [ID_W-1:0]                up_req_id_o,
    input  logic                           up_rsp_valid_i,
    input  logic [ID_W-1:0]                up_rsp_id_i,
    output logic                           error_o,
    output logic                           busy_o
);

    localparam int N_IDS = 1 << ID_W;

    if (N_PORTS < 2 || AGGR_W <= LEVEL || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("fractal_sync_nd_node: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEND_UP,
        ST_WAIT_UP,
        ST_BCAST
    } state_e;

    state_e             state_q [N_IDS];
    state_e             state_d [N_IDS];
    logic [N_PORTS-1:0] mask_q  [N_IDS];
    logic [N_PORTS-1:0] mask_d  [N_IDS];
    logic [N_PORTS-1:0] pend_q  [N_IDS];
    logic [N_PORTS-1:0] pend_d  [N_IDS];
    logic [AGGR_W-1:0]  aggr_q  [N_IDS];
    logic [AGGR_W-1:0]  aggr_d  [N_IDS];
    logic [N_PORTS-1:0] rsp_clr [N_IDS];

    logic [N_PORTS-1:0] fire;
    logic               up_fire;
    logic               up_vld_q, up_vld_d;
    logic [ID_W-1:0]    up_id_q, up_id_d;
    logic [AGGR_W-1:0]  up_aggr_q, up_aggr_d;
    logic               err_q, err_d;

    // Per-entry scratch used while folding this cycle's arrivals.
    logic [AGGR_W-1:0]  ref_aggr;
    logic               have_ref;
    logic               arrived;
    logic [N_PORTS-1:0] new_mask;

`ifdef FRACTAL_SYNC_ND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q [N_IDS];
    logic [TW-1:0] cnt_d [N_IDS];
`endif

    // A barrier is rooted here when no aggregation bit above this level is set.
    function automatic logic is_root(input logic [AGGR_W-1:0] a);
        return (a >> (LEVEL + 1)) == '0;
    endfunction

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            req_ready_o[p] = (state_q[req_id_i[p]] == ST_IDLE) ||
                             (state_q[req_id_i[p]] == ST_COLLECT);
        end
    end

    assign fire    = req_valid_i & req_ready_o;
    assign up_fire = up_vld_q & up_req_ready_i;

    // Each child port serves the lowest broadcasting id it still owes a response.
    always_comb begin
        rsp_valid_o = '0;
        rsp_id_o    = '0;
        for (int i = 0; i < N_IDS; i++) begin
            rsp_clr[i] = '0;
        end
        for (int p = 0; p < N_PORTS; p++) begin
            for (int i = 0; i < N_IDS; i++) begin
                if (!rsp_valid_o[p] && state_q[i] == ST_BCAST && pend_q[i][p]) begin
                    rsp_valid_o[p] = 1'b1;
                    rsp_id_o[p]    = ID_W'(i);
                    rsp_clr[i][p]  = rsp_ready_i[p];
                end
            end
        end
    end

    always_comb begin
        err_d    = 1'b0;
        ref_aggr = '0;
        have_ref = 1'b0;
        arrived  = 1'b0;
        new_mask = '0;
        for (int i = 0; i < N_IDS; i++) begin
            state_d[i] = state_q[i];
            mask_d[i]  = mask_q[i];
            pend_d[i]  = pend_q[i];
            aggr_d[i]  = aggr_q[i];
`ifdef FRACTAL_SYNC_ND_TIMEOUT_EN
            cnt_d[i]   = '0;
`endif
            case (state_q[i])
                ST_IDLE, ST_COLLECT: begin
                    // In IDLE the first good arrival (lowest port) becomes the reference aggr.
                    have_ref = (state_q[i] == ST_COLLECT);
                    ref_aggr = aggr_q[i];
                    new_mask = mask_q[i];
                    arrived  = 1'b0;
                    for (int p = 0; p < N_PORTS; p++) begin
                        if (fire[p] && req_id_i[p] == ID_W'(i)) begin
                            if (!req_aggr_i[p][LEVEL]) begin
                                err_d = 1'b1;
                            end else if (have_ref && req_aggr_i[p] != ref_aggr) begin
                                err_d = 1'b1;
                            end else if (mask_q[i][p]) begin
                                err_d = 1'b1;
                            end else begin
                                new_mask[p] = 1'b1;
                                arrived     = 1'b1;
                                if (!have_ref) begin
                                    ref_aggr = req_aggr_i[p];
                                    have_ref = 1'b1;
                                end
                            end
                        end
                    end
                    if (arrived) begin
                        mask_d[i] = new_mask;
                        aggr_d[i] = ref_aggr;
                        if (&new_mask) begin
                            if (is_root(ref_aggr)) begin
                                state_d[i] = ST_BCAST;
                                pend_d[i]  = '1;
                            end else begin
                                state_d[i] = ST_SEND_UP;
                            end
                        end else begin
                            state_d[i] = ST_COLLECT;
                        end
                    end
`ifdef FRACTAL_SYNC_ND_TIMEOUT_EN
                    else if (state_q[i] == ST_COLLECT) begin
                        if (cnt_q[i] == TW'(TIMEOUT_CYCLES - 1)) begin
                            state_d[i] = ST_IDLE;
                            mask_d[i]  = '0;
                            err_d      = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + TW'(1);
                        end
                    end
`endif
                end
                ST_SEND_UP: begin
                    if (up_fire && up_id_q == ID_W'(i)) begin
                        state_d[i] = ST_WAIT_UP;
                    end
                end
                ST_WAIT_UP: begin
                    if (up_rsp_valid_i && up_rsp_id_i == ID_W'(i)) begin
                        state_d[i] = ST_BCAST;
                        pend_d[i]  = '1;
                    end
                end
                ST_BCAST: begin
                    pend_d[i] = pend_q[i] & ~rsp_clr[i];
                    if (pend_d[i] == '0) begin
                        state_d[i] = ST_IDLE;
                        mask_d[i]  = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
        if (up_rsp_valid_i && state_q[up_rsp_id_i] != ST_WAIT_UP) begin
            err_d = 1'b1;
        end
    end

    // Upstream slot: reload only when empty or draining, so the payload is stable under stall.
    always_comb begin
        up_vld_d  = up_vld_q;
        up_id_d   = up_id_q;
        up_aggr_d = up_aggr_q;
        if (!up_vld_q || up_fire) begin
            up_vld_d  = 1'b0;
            up_id_d   = '0;
            up_aggr_d = '0;
            for (int i = N_IDS - 1; i >= 0; i--) begin
                if (state_d[i] == ST_SEND_UP) begin
                    up_vld_d  = 1'b1;
                    up_id_d   = ID_W'(i);
                    up_aggr_d = aggr_d[i];
                end
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < N_IDS; i++) begin
            if (state_q[i] != ST_IDLE) begin
                busy_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_IDS; i++) begin
                state_q[i] <= ST_IDLE;
                mask_q[i]  <= '0;
                pend_q[i]  <= '0;
                aggr_q[i]  <= '0;
            end
            up_vld_q  <= 1'b0;
            up_id_q   <= '0;
            up_aggr_q <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_IDS; i++) begin
                state_q[i] <= state_d[i];
                mask_q[i]  <= mask_d[i];
                pend_q[i]  <= pend_d[i];
                aggr_q[i]  <= aggr_d[i];
            end
            up_vld_q  <= up_vld_d;
            up_id_q   <= up_id_d;
            up_aggr_q <= up_aggr_d;
            err_q     <= err_d;
        end
    end

`ifdef FRACTAL_SYNC_ND_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_IDS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IDS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

    assign up_req_valid_o = up_vld_q;
    assign up_req_id_o    = up_id_q;
    assign up_req_aggr_o  = up_aggr_q;
    assign error_o        = err_q;

endmodule

// File: tb/tb_fractal_sync_nd_node.sv
// Self-checking bench for fractal_sync_nd_node (N_PORTS=4, LEVEL=0, AGGR_W=8, ID_W=2).
// Single-cycle vectors from a table, hand sequences for multi-cycle corners,
// then randomized legal traffic against a per-barrier bookkeeping model.

module tb_fractal_sync_nd_node;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [3:0][7:0] req_aggr;
    logic [3:0][1:0] req_id;
    logic [3:0]      rsp_valid;
    logic [3:0]      rsp_ready;
    logic [3:0][1:0] rsp_id;
    logic            up_req_valid;
    logic            up_req_ready;
    logic [7:0]      up_req_aggr;
    logic [1:0]      up_req_id;
    logic            up_rsp_valid;
    logic [1:0]      up_rsp_id;
    logic            error;
    logic            busy;

    always #5 clk = ~clk;

    fractal_sync_nd_node #(
        .N_PORTS(4), .LEVEL(0), .AGGR_W(8), .ID_W(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_aggr_i(req_aggr), .req_id_i(req_id),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .up_req_valid_o(up_req_valid), .up_req_ready_i(up_req_ready),
        .up_req_aggr_o(up_req_aggr), .up_req_id_o(up_req_id),
        .up_rsp_valid_i(up_rsp_valid), .up_rsp_id_i(up_rsp_id),
        .error_o(error), .busy_o(busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] vld;
        logic [1:0] id;
        logic [7:0] aggr;   // ports 0..2
        logic [7:0] aggr3;  // port 3
        logic       exp_err;
        logic [3:0] exp_rsp;
        logic       exp_up;
        logic       exp_busy;
    } vec_t;
    vec_t vecs[6];

    // random-phase model state
    bit         sent[4][4];
    bit         got[4][4];
    int         arr_cnt[4];
    int         rsp_cnt[4];
    bit         released[4];
    bit         fwd[4];
    logic [7:0] round_aggr[4];
    bit         fired[4];
    int         pq_id[$];
    int         pq_due[$];
    bit         prev_hold;
    logic [1:0] prev_id;
    logic [7:0] prev_aggr;
    bit         drain;
    int         sel;
    int         rid;
    int         seen_at;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid    = '0;
        req_aggr     = '0;
        req_id       = '0;
        rsp_ready    = '0;
        up_req_ready = 1'b0;
        up_rsp_valid = 1'b0;
        up_rsp_id    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input logic [3:0] vld, input logic [1:0] id, input logic [7:0] aggr);
        req_valid = vld;
        for (int p = 0; p < 4; p++) begin
            req_id[p]   = id;
            req_aggr[p] = aggr;
        end
    endtask

    function automatic logic [7:0] pick_aggr();
        case ($urandom_range(0, 3))
            0:       return 8'h01;
            1:       return 8'h03;
            2:       return 8'h05;
            default: return 8'h81;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'hF, 2'd1, 8'h01, 8'h01, 1'b0, 4'hF, 1'b0, 1'b1}; // root, all in one cycle
        vecs[1] = '{4'hF, 2'd2, 8'h03, 8'h03, 1'b0, 4'h0, 1'b1, 1'b1}; // forwarded upstream
        vecs[2] = '{4'hF, 2'd0, 8'h01, 8'h03, 1'b1, 4'h0, 1'b0, 1'b1}; // port3 mismatches lower ports
        vecs[3] = '{4'h1, 2'd3, 8'h02, 8'h02, 1'b1, 4'h0, 1'b0, 1'b0}; // own level bit clear: dropped
        vecs[4] = '{4'h3, 2'd0, 8'h05, 8'h05, 1'b0, 4'h0, 1'b0, 1'b1}; // partial arrival
        vecs[5] = '{4'hF, 2'd3, 8'h81, 8'h81, 1'b0, 4'h0, 1'b1, 1'b1}; // top bit set: not root

        // reset state
        do_reset();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_up_valid", up_req_valid, 0);
        chk("rst_up_id", up_req_id, 0);
        chk("rst_up_aggr", up_req_aggr, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 4'hF);

        // table vectors: one request cycle from reset, outputs one cycle later
        for (int v = 0; v < 6; v++) begin
            do_reset();
            drive_req(vecs[v].vld, vecs[v].id, vecs[v].aggr);
            req_aggr[3] = vecs[v].aggr3;
            tick();
            req_valid = '0;
            chk($sformatf("vec%0d_err", v), error, vecs[v].exp_err);
            chk($sformatf("vec%0d_rsp", v), rsp_valid, vecs[v].exp_rsp);
            chk($sformatf("vec%0d_up", v), up_req_valid, vecs[v].exp_up);
            chk($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
        end

        // root barrier: ids on every port, then release drains the entry
        do_reset();
        drive_req(4'hF, 2'd1, 8'h01);
        tick();
        req_valid = '0;
        chk("root_rsp_valid", rsp_valid, 4'hF);
        chk("root_rsp_id", rsp_id, 8'h55);
        rsp_ready = 4'hF;
        tick();
        rsp_ready = '0;
        chk("root_busy_after", busy, 0);
        chk("root_rsp_after", rsp_valid, 0);

        // forwarding with staggered arrivals 0,3,5,9; ready at 12; parent release at 20
        do_reset();
        for (int c = 0; c < 22; c++) begin
            if (c == 9 || c == 13) chk($sformatf("fwd_up_valid_c%0d", c), up_req_valid, 0);
            if (c >= 10 && c <= 12) begin
                chk($sformatf("fwd_up_valid_c%0d", c), up_req_valid, 1);
                chk($sformatf("fwd_up_aggr_c%0d", c), up_req_aggr, 8'h03);
                chk($sformatf("fwd_up_id_c%0d", c), up_req_id, 2);
            end
            if (c == 20) chk("fwd_rsp_before", rsp_valid, 0);
            if (c == 21) chk("fwd_rsp_after", rsp_valid, 4'hF);
            drive_req((c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 :
                      (c == 5) ? 4'b0100 : (c == 9) ? 4'b1000 : 4'b0000, 2'd2, 8'h03);
            up_req_ready = (c == 12);
            up_rsp_valid = (c == 20);
            up_rsp_id    = 2'd2;
            tick();
        end

        // backpressure: port 3 stalls while others drain
        do_reset();
        drive_req(4'hF, 2'd0, 8'h01);
        tick();
        req_valid = '0;
        rsp_ready = 4'b0111;
        tick();
        chk("bp_rsp_valid", rsp_valid, 4'b1000);
        chk("bp_rsp_id3", rsp_id[3], 0);
        chk("bp_req_ready", req_ready, 4'h0);
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = '0;
        chk("bp_rsp_done", rsp_valid, 0);
        chk("bp_busy", busy, 0);
        chk("bp_req_ready_back", req_ready, 4'hF);

        // errors: duplicate arrival, then stray upstream response, then completion
        do_reset();
        drive_req(4'b0010, 2'd3, 8'h01);
        tick();
        chk("dup_err_first", error, 0);
        tick();
        req_valid = '0;
        chk("dup_err_pulse", error, 1);
        tick();
        chk("dup_err_clear", error, 0);
        chk("dup_busy", busy, 1);
        up_rsp_valid = 1'b1;
        up_rsp_id    = 2'd3;
        tick();
        up_rsp_valid = 1'b0;
        chk("stray_up_err", error, 1);
        chk("stray_up_no_rsp", rsp_valid, 0);
        drive_req(4'b1101, 2'd3, 8'h01);
        tick();
        req_valid = '0;
        chk("dup_complete_rsp", rsp_valid, 4'hF);
        chk("dup_complete_err", error, 0);

        // interleave: ids 1 and 2 both wait upstream; lowest goes first
        do_reset();
        drive_req(4'hF, 2'd1, 8'h03);
        tick();
        drive_req(4'hF, 2'd2, 8'h03);
        tick();
        req_valid = '0;
        chk("il_first_valid", up_req_valid, 1);
        chk("il_first_id", up_req_id, 1);
        up_req_ready = 1'b1;
        tick();
        chk("il_second_valid", up_req_valid, 1);
        chk("il_second_id", up_req_id, 2);
        tick();
        up_req_ready = 1'b0;
        chk("il_empty", up_req_valid, 0);

`ifdef FRACTAL_SYNC_ND_TIMEOUT_EN
        // abandoned collection times out with a single error pulse
        do_reset();
        drive_req(4'b0001, 2'd0, 8'h01);
        tick();
        req_valid = '0;
        seen_at = -1;
        for (int k = 1; k <= 40; k++) begin
            if (seen_at < 0 && error) seen_at = k;
            tick();
        end
        chk("to_error_seen", (seen_at == 16 || seen_at == 17), 1);
        chk("to_busy", busy, 0);
        chk("to_no_rsp", rsp_valid, 0);
`else
        // randomized legal traffic with a parent model
        do_reset();
        for (int i = 0; i < 4; i++) begin
            round_aggr[i] = pick_aggr();
            arr_cnt[i] = 0; rsp_cnt[i] = 0; released[i] = 0; fwd[i] = 0;
            fired[i] = 0;
            for (int p = 0; p < 4; p++) begin sent[p][i] = 0; got[p][i] = 0; end
        end
        prev_hold = 0;
        for (int cyc = 0; cyc < 3400; cyc++) begin
            drain = (cyc >= 3000);
            if (drain && !busy && req_valid == 0 && pq_id.size() == 0) break;
            // drive phase
            for (int p = 0; p < 4; p++) begin
                if (fired[p]) req_valid[p] = 1'b0;
                if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
                    sel = $urandom_range(0, 3);
                    if (!sent[p][sel] && (!drain || arr_cnt[sel] > 0)) begin
                        req_valid[p] = 1'b1;
                        req_id[p]    = sel[1:0];
                        req_aggr[p]  = round_aggr[sel];
                    end
                end
            end
            up_rsp_valid = 1'b0;
            if (pq_id.size() > 0 && pq_due[0] <= cyc) begin
                up_rsp_valid = 1'b1;
                rid = pq_id.pop_front();
                up_rsp_id = rid[1:0];
                void'(pq_due.pop_front());
            end
            rsp_ready    = drain ? 4'hF : 4'($urandom);
            up_req_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            // check phase
            chk("rnd_no_error", error, 0);
            if (prev_hold) begin
                chk("rnd_up_hold_valid", up_req_valid, 1);
                chk("rnd_up_hold_id", up_req_id, prev_id);
                chk("rnd_up_hold_aggr", up_req_aggr, prev_aggr);
            end
            for (int p = 0; p < 4; p++) begin
                if (rsp_valid[p]) begin
                    rid = rsp_id[p];
                    chk($sformatf("rnd_rsp_legal_p%0d", p),
                        released[rid] && sent[p][rid] && !got[p][rid], 1);
                end
                if (req_valid[p]) begin
                    rid = req_id[p];
                    chk($sformatf("rnd_req_ready_p%0d", p), req_ready[p], arr_cnt[rid] < 4);
                end
            end
            for (int p = 0; p < 4; p++) begin
                fired[p] = req_valid[p] && req_ready[p];
                if (fired[p]) begin
                    rid = req_id[p];
                    sent[p][rid] = 1;
                    arr_cnt[rid]++;
                    if (arr_cnt[rid] == 4 && (round_aggr[rid] >> 1) == 0) released[rid] = 1;
                end
            end
            if (up_req_valid && up_req_ready) begin
                rid = up_req_id;
                chk("rnd_up_legal", arr_cnt[rid] == 4 && !fwd[rid] &&
                    (round_aggr[rid] >> 1) != 0 && up_req_aggr == round_aggr[rid], 1);
                fwd[rid] = 1;
                pq_id.push_back(rid);
                pq_due.push_back(cyc + $urandom_range(1, 6));
            end
            if (up_rsp_valid) released[up_rsp_id] = 1;
            for (int p = 0; p < 4; p++) begin
                if (rsp_valid[p] && rsp_ready[p]) begin
                    rid = rsp_id[p];
                    got[p][rid] = 1;
                    rsp_cnt[rid]++;
                    if (rsp_cnt[rid] == 4) begin
                        for (int q = 0; q < 4; q++) begin sent[q][rid] = 0; got[q][rid] = 0; end
                        arr_cnt[rid] = 0; rsp_cnt[rid] = 0;
                        released[rid] = 0; fwd[rid] = 0;
                        round_aggr[rid] = pick_aggr();
                    end
                end
            end
            prev_hold = up_req_valid && !up_req_ready;
            prev_id   = up_req_id;
            prev_aggr = up_req_aggr;
            @(posedge clk);
            #1;
        end
        chk("rnd_drain_busy", busy, 0);
        chk("rnd_drain_parent", pq_id.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
